// File: rtl/mips_irq_fabric_if.sv
// Core-side coprocessor/device bus and interrupt handshake of mips_irq_fabric.
// The core side uses the master modport; the fabric uses the slave modport.
interface mips_irq_fabric_if;
    logic [31:0] cop_addr_i;
    logic [31:0] cop_data_i;
    logic [3:0]  cop_we_i;
    logic        cop_re_i;
    logic [31:0] cop_dout_o;
    logic        irq_ack_i;
    logic        irq_req_o;
    logic [31:0] irq_addr_o;

    modport master (
        output cop_addr_i, cop_data_i, cop_we_i, cop_re_i, irq_ack_i,
        input  cop_dout_o, irq_req_o, irq_addr_o
    );

    modport slave (
        input  cop_addr_i, cop_data_i, cop_we_i, cop_re_i, irq_ack_i,
        output cop_dout_o, irq_req_o, irq_addr_o
    );
endinterface

// File: rtl/mips_irq_fabric.sv
// Device-window decoder plus vectored, prioritised interrupt controller
// sitting between the core's device port and N_DEV peripheral slots.
module mips_irq_fabric #(
    parameter int unsigned N_DEV      = 4,
    parameter logic [31:0] DEV_BASE   = 32'hFFFF_0000,
    parameter int unsigned SLOT_AW    = 8,
    parameter logic [31:0] VEC_STRIDE = 32'h80
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_irq_fabric_if.slave       cop,
    output logic [N_DEV-1:0]       dev_sel_o,
    output logic [SLOT_AW-1:0]     dev_addr_o,
    output logic [31:0]            dev_wdata_o,
    output logic [3:0]             dev_we_o,
    input  logic [32*N_DEV-1:0]    dev_rdata_i,
    input  logic [N_DEV-1:0]       dev_irq_i
);

    localparam int unsigned TAG_LSB   = SLOT_AW + 4;
    localparam int unsigned OW        = SLOT_AW - 2;
    localparam logic [4:0]  CTRL_SLOT = 5'(N_DEV);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC} state_e;

    state_e             state_q;
    logic [N_DEV-1:0]   enable_q, pending_q, irq_prev_q, armed_q;
    logic [31:0]        vbase_q, cop_dout_q, irq_addr_q;
    logic [3:0]         chan_q;
    logic               irq_req_q;

    logic               hit_c, access_c, ctrl_c, ctrl_wr_c;
    logic               wr_en_c, wr_pend_c, wr_vbase_c, wr_eoi_c, ack_c;
    logic [3:0]         slot_c, winner_c;
    logic [OW-1:0]      reg_idx_c;
    logic [31:0]        rdata_c, vector_c;
    logic [N_DEV-1:0]   elig_c, edge_c;
    logic [N_DEV-1:0]   enable_d, pending_d;
    logic [31:0]        vbase_d;

    // Address decode and device-side strobes
    always_comb begin
        hit_c      = cop.cop_addr_i[31:TAG_LSB] == DEV_BASE[31:TAG_LSB];
        slot_c     = cop.cop_addr_i[TAG_LSB-1:SLOT_AW];
        access_c   = (|cop.cop_we_i) || cop.cop_re_i;
        ctrl_c     = hit_c && ({1'b0, slot_c} == CTRL_SLOT);
        reg_idx_c  = cop.cop_addr_i[SLOT_AW-1:2];
        ctrl_wr_c  = ctrl_c && (|cop.cop_we_i);
        wr_en_c    = ctrl_wr_c && (reg_idx_c == OW'(0));
        wr_pend_c  = ctrl_wr_c && (reg_idx_c == OW'(1));
        wr_vbase_c = ctrl_wr_c && (reg_idx_c == OW'(2));
        wr_eoi_c   = ctrl_wr_c && (reg_idx_c == OW'(3));
        dev_sel_o  = '0;
        for (int k = 0; k < int'(N_DEV); k++) begin
            if (hit_c && access_c && (slot_c == 4'(k))) dev_sel_o[k] = 1'b1;
        end
        dev_we_o    = (|dev_sel_o) ? cop.cop_we_i : 4'h0;
        dev_addr_o  = cop.cop_addr_i[SLOT_AW-1:0];
        dev_wdata_o = cop.cop_data_i;
    end

    // Read mux: device slots, controller registers, zero elsewhere
    always_comb begin
        rdata_c = '0;
        if (hit_c) begin
            for (int k = 0; k < int'(N_DEV); k++) begin
                if (slot_c == 4'(k)) rdata_c = dev_rdata_i[32*k +: 32];
            end
        end
        if (ctrl_c) begin
            if (reg_idx_c == OW'(0))      rdata_c = 32'(enable_q);
            else if (reg_idx_c == OW'(1)) rdata_c = 32'(pending_q);
            else if (reg_idx_c == OW'(2)) rdata_c = vbase_q;
            else if (reg_idx_c == OW'(3)) rdata_c = {27'b0, state_q == ST_SVC, chan_q};
            else                          rdata_c = '0;
        end
    end

    // Priority pick and register-file next state; set beats W1C, ack clear stacks with W1C
    always_comb begin
        elig_c   = pending_q & enable_q;
        winner_c = '0;
        for (int k = int'(N_DEV) - 1; k >= 0; k--) begin
            if (elig_c[k]) winner_c = 4'(k);
        end
        vector_c = vbase_q + 32'(winner_c) * VEC_STRIDE;
        ack_c    = (state_q == ST_REQ) && cop.irq_ack_i && (|elig_c);
        // A line must be sampled low after reset before its rise counts
        edge_c   = dev_irq_i & ~irq_prev_q & armed_q;

        pending_d = pending_q;
        if (wr_pend_c) pending_d = pending_d & ~cop.cop_data_i[N_DEV-1:0];
        for (int k = 0; k < int'(N_DEV); k++) begin
            if (ack_c && (winner_c == 4'(k))) pending_d[k] = 1'b0;
        end
        pending_d = pending_d | edge_c;

        enable_d = wr_en_c    ? cop.cop_data_i[N_DEV-1:0]    : enable_q;
        vbase_d  = wr_vbase_c ? {cop.cop_data_i[31:2], 2'b00} : vbase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            enable_q   <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
            armed_q    <= '0;
            vbase_q    <= '0;
            cop_dout_q <= '0;
            irq_addr_q <= '0;
            chan_q     <= '0;
            irq_req_q  <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            vbase_q    <= vbase_d;
            irq_prev_q <= dev_irq_i;
            armed_q    <= armed_q | ~dev_irq_i;
            if (cop.cop_re_i) cop_dout_q <= rdata_c;
            case (state_q)
                ST_IDLE: begin
                    if (|elig_c) begin
                        state_q    <= ST_REQ;
                        irq_req_q  <= 1'b1;
                        irq_addr_q <= vector_c;
                    end
                end
                ST_REQ: begin
                    irq_addr_q <= vector_c;
                    if (ack_c) begin
                        state_q   <= ST_SVC;
                        irq_req_q <= 1'b0;
                        chan_q    <= winner_c;
                    end else if (!(|elig_c)) begin
                        state_q   <= ST_IDLE;
                        irq_req_q <= 1'b0;
                    end
                end
                ST_SVC: begin
                    if (wr_eoi_c) state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign cop.cop_dout_o = cop_dout_q;
    assign cop.irq_req_o  = irq_req_q;
    assign cop.irq_addr_o = irq_addr_q;

endmodule

// File: tb/tb_mips_irq_fabric.sv
// Directed bench for mips_irq_fabric (N_DEV=4): decode, read path, interrupt
// sequencing, masking, same-cycle races and reset behaviour.
module tb_mips_irq_fabric;

    localparam logic [31:0] R_EN  = 32'hFFFF_0400;
    localparam logic [31:0] R_PND = 32'hFFFF_0404;
    localparam logic [31:0] R_VB  = 32'hFFFF_0408;
    localparam logic [31:0] R_CUR = 32'hFFFF_040C;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   dev_sel;
    logic [7:0]   dev_addr;
    logic [31:0]  dev_wdata;
    logic [3:0]   dev_we;
    logic [127:0] dev_rdata;
    logic [3:0]   dev_irq;
    logic [31:0]  rv;
    int           errors = 0;
    int           checks = 0;

    mips_irq_fabric_if bus ();

    mips_irq_fabric dut (
        .clk         (clk),
        .rst         (rst),
        .cop         (bus),
        .dev_sel_o   (dev_sel),
        .dev_addr_o  (dev_addr),
        .dev_wdata_o (dev_wdata),
        .dev_we_o    (dev_we),
        .dev_rdata_i (dev_rdata),
        .dev_irq_i   (dev_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.cop_addr_i = a;
        bus.cop_data_i = d;
        bus.cop_we_i   = 4'hF;
        cyc();
        bus.cop_we_i   = 4'h0;
        bus.cop_addr_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.cop_addr_i = a;
        bus.cop_re_i   = 1'b1;
        cyc();
        bus.cop_re_i   = 1'b0;
        bus.cop_addr_i = '0;
        d = bus.cop_dout_o;
    endtask

    initial begin
        rst            = 1'b1;
        bus.cop_addr_i = '0;
        bus.cop_data_i = '0;
        bus.cop_we_i   = '0;
        bus.cop_re_i   = 1'b0;
        bus.irq_ack_i  = 1'b0;
        dev_irq        = '0;
        dev_rdata      = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        #2;
        chk("reset_dout", bus.cop_dout_o, 32'h0);
        chk("reset_req", 32'(bus.irq_req_o), 32'h0);
        chk("reset_addr", bus.irq_addr_o, 32'h0);
        chk("idle_sel", 32'(dev_sel), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Decode of a device write
        bus.cop_addr_i = 32'hFFFF_0204;
        bus.cop_data_i = 32'hA5A5_0001;
        bus.cop_we_i   = 4'hF;
        #1;
        chk("dec_sel", 32'(dev_sel), 32'h4);
        chk("dec_addr", 32'(dev_addr), 32'h04);
        chk("dec_we", 32'(dev_we), 32'hF);
        chk("dec_wdata", dev_wdata, 32'hA5A5_0001);
        bus.cop_addr_i = 32'h1234_0104;
        #1;
        chk("miss_sel", 32'(dev_sel), 32'h0);
        chk("miss_we", 32'(dev_we), 32'h0);
        cyc();
        bus.cop_we_i = 4'h0;

        // Read path: slot data, hold, unmapped slot reads zero
        rd(32'hFFFF_0100, rv);
        chk("rd_slot1", rv, 32'hD000_0001);
        cyc();
        chk("rd_hold", bus.cop_dout_o, 32'hD000_0001);
        bus.cop_addr_i = 32'hFFFF_0600;
        bus.cop_re_i   = 1'b1;
        #1;
        chk("rd_slot6_sel", 32'(dev_sel), 32'h0);
        cyc();
        bus.cop_re_i = 1'b0;
        chk("rd_slot6", bus.cop_dout_o, 32'h0);

        // Controller register setup
        rd(R_EN, rv);
        chk("en_reset", rv, 32'h0);
        wr(R_VB, 32'h8000_0003);
        rd(R_VB, rv);
        chk("vbase_rb", rv, 32'h8000_0000);
        wr(R_EN, 32'hFFFF_FFFF);
        rd(R_EN, rv);
        chk("en_rb", rv, 32'hF);

        // Single interrupt on ch2
        dev_irq = 4'b0100;
        cyc();
        dev_irq = 4'b0000;
        chk("single_req_t1", 32'(bus.irq_req_o), 32'h0);
        cyc();
        chk("single_req_t2", 32'(bus.irq_req_o), 32'h1);
        chk("single_vec", bus.irq_addr_o, 32'h8000_0100);
        bus.irq_ack_i = 1'b1;
        cyc();
        bus.irq_ack_i = 1'b0;
        chk("single_ack_req", 32'(bus.irq_req_o), 32'h0);
        rd(R_CUR, rv);
        chk("single_cur", rv, 32'h12);
        rd(R_PND, rv);
        chk("single_pnd", rv, 32'h0);
        wr(R_CUR, 32'h0);
        rd(R_CUR, rv);
        chk("single_eoi_cur", rv, 32'h02);
        chk("single_eoi_req", 32'(bus.irq_req_o), 32'h0);

        // Priority and nesting: ch1 and ch3 together
        dev_irq = 4'b1010;
        cyc();
        dev_irq = 4'b0000;
        cyc();
        chk("prio_req", 32'(bus.irq_req_o), 32'h1);
        chk("prio_vec1", bus.irq_addr_o, 32'h8000_0080);
        bus.irq_ack_i = 1'b1;
        cyc();
        bus.irq_ack_i = 1'b0;
        cyc();
        cyc();
        chk("prio_svc_req", 32'(bus.irq_req_o), 32'h0);
        rd(R_CUR, rv);
        chk("prio_cur", rv, 32'h11);
        wr(R_CUR, 32'h0);
        chk("prio_eoi_t1", 32'(bus.irq_req_o), 32'h0);
        cyc();
        chk("prio_eoi_t2", 32'(bus.irq_req_o), 32'h1);
        chk("prio_vec3", bus.irq_addr_o, 32'h8000_0180);
        bus.irq_ack_i = 1'b1;
        cyc();
        bus.irq_ack_i = 1'b0;
        wr(R_CUR, 32'h0);

        // Masking and W1C during REQ
        wr(R_EN, 32'h0);
        dev_irq = 4'b0001;
        cyc();
        dev_irq = 4'b0000;
        cyc();
        rd(R_PND, rv);
        chk("mask_pnd", rv, 32'h1);
        chk("mask_req", 32'(bus.irq_req_o), 32'h0);
        wr(R_EN, 32'h1);
        chk("unmask_t1", 32'(bus.irq_req_o), 32'h0);
        cyc();
        chk("unmask_t2", 32'(bus.irq_req_o), 32'h1);
        chk("unmask_vec", bus.irq_addr_o, 32'h8000_0000);
        wr(R_PND, 32'h1);
        cyc();
        chk("w1c_req_drop", 32'(bus.irq_req_o), 32'h0);
        rd(R_PND, rv);
        chk("w1c_pnd", rv, 32'h0);

        // Race: W1C and edge on the same bit
        wr(R_EN, 32'h0);
        dev_irq = 4'b0001;
        wr(R_PND, 32'h1);
        dev_irq = 4'b0000;
        rd(R_PND, rv);
        chk("race_w1c_set", rv, 32'h1);
        wr(R_PND, 32'h1);
        rd(R_PND, rv);
        chk("race_clear", rv, 32'h0);

        // Race: ack alongside a higher-priority edge
        wr(R_EN, 32'hF);
        dev_irq = 4'b0100;
        cyc();
        dev_irq = 4'b0000;
        cyc();
        chk("race_ack_vec", bus.irq_addr_o, 32'h8000_0100);
        bus.irq_ack_i = 1'b1;
        dev_irq       = 4'b0001;
        cyc();
        bus.irq_ack_i = 1'b0;
        dev_irq       = 4'b0000;
        chk("race_ack_req", 32'(bus.irq_req_o), 32'h0);
        rd(R_CUR, rv);
        chk("race_ack_cur", rv, 32'h12);
        rd(R_PND, rv);
        chk("race_ack_pnd", rv, 32'h1);
        wr(R_CUR, 32'h0);
        cyc();
        chk("race_next_req", 32'(bus.irq_req_o), 32'h1);
        chk("race_next_vec", bus.irq_addr_o, 32'h8000_0000);
        bus.irq_ack_i = 1'b1;
        cyc();
        bus.irq_ack_i = 1'b0;

        // Reset in SVC with PENDING=0xA, line held high through release
        dev_irq = 4'b1010;
        cyc();
        dev_irq = 4'b0000;
        cyc();
        rd(R_PND, rv);
        chk("pre_rst_pnd", rv, 32'hA);
        dev_irq = 4'b0100;
        rst     = 1'b1;
        #1;
        chk("rst_dout", bus.cop_dout_o, 32'h0);
        chk("rst_req", 32'(bus.irq_req_o), 32'h0);
        chk("rst_addr", bus.irq_addr_o, 32'h0);
        cyc();
        rst = 1'b0;
        rd(R_EN, rv);
        chk("rst_en", rv, 32'h0);
        rd(R_PND, rv);
        chk("rst_pnd", rv, 32'h0);
        rd(R_VB, rv);
        chk("rst_vb", rv, 32'h0);
        rd(R_CUR, rv);
        chk("rst_cur", rv, 32'h0);
        wr(R_EN, 32'hF);
        cyc();
        cyc();
        cyc();
        chk("held_req", 32'(bus.irq_req_o), 32'h0);
        rd(R_PND, rv);
        chk("held_pnd", rv, 32'h0);
        dev_irq = 4'b0000;
        cyc();
        dev_irq = 4'b0100;
        cyc();
        dev_irq = 4'b0000;
        cyc();
        chk("retoggle_req", 32'(bus.irq_req_o), 32'h1);
        chk("retoggle_vec", bus.irq_addr_o, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
